// File: rtl/seq_alu_pkg.sv
// Shared opcodes, FSM state encoding and opcode classification for seq_alu.
package seq_alu_pkg;

    localparam logic [3:0] OP_ADDU        = 4'd0;
    localparam logic [3:0] OP_ADDS        = 4'd1;
    localparam logic [3:0] OP_SUBU        = 4'd2;
    localparam logic [3:0] OP_SUBS        = 4'd3;
    localparam logic [3:0] OP_AND         = 4'd4;
    localparam logic [3:0] OP_OR          = 4'd5;
    localparam logic [3:0] OP_XOR         = 4'd6;
    localparam logic [3:0] OP_SRA1        = 4'd7;
    localparam logic [3:0] OP_SLL         = 4'd8;
    localparam logic [3:0] OP_SRL         = 4'd9;
    localparam logic [3:0] OP_SRA         = 4'd10;
    localparam logic [3:0] OP_MULU        = 4'd11;
    localparam logic [3:0] OP_ILLEGAL_MIN = 4'd12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_t;

    // Shifts and multiply run one step per cycle in seq_alu_iter.
    function automatic logic is_iterative(input logic [3:0] op);
        return (op >= OP_SLL) && (op <= OP_MULU);
    endfunction

endpackage

// File: rtl/seq_alu_iter.sv
// Iterative datapath: variable shifts (one bit per cycle) and shift-add multiply.
// The top pulses start on accept; last is high during the final step, and
// res_next/hi_nz_next then carry the finished values for the top to register.
module seq_alu_iter
    import seq_alu_pkg::*;
#(
    parameter int NUMBITS = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [3:0]         op,
    input  logic [NUMBITS-1:0] a,
    input  logic [NUMBITS-1:0] b,
    output logic               last,
    output logic [NUMBITS-1:0] res_next,
    output logic               hi_nz_next
);

    localparam int SHW = $clog2(NUMBITS);
    localparam int CW  = $clog2(NUMBITS + 1);

    logic [CW-1:0]        cnt;
    logic [3:0]           op_q;
    logic [2*NUMBITS-1:0] sreg, sreg_n;
    logic [2*NUMBITS-1:0] acc, acc_n;
    logic [NUMBITS-1:0]   mpl, mpl_n;

    // One step of the selected operation; shifts only use the low half of sreg.
    always_comb begin
        sreg_n = sreg;
        acc_n  = acc;
        mpl_n  = mpl >> 1;
        case (op_q)
            OP_SLL:  sreg_n = {{NUMBITS{1'b0}}, sreg[NUMBITS-2:0], 1'b0};
            OP_SRL:  sreg_n = {{NUMBITS{1'b0}}, 1'b0, sreg[NUMBITS-1:1]};
            OP_SRA:  sreg_n = {{NUMBITS{1'b0}}, sreg[NUMBITS-1], sreg[NUMBITS-1:1]};
            OP_MULU: begin
                acc_n  = mpl[0] ? (acc + sreg) : acc;
                sreg_n = sreg << 1;
            end
            default: ;
        endcase
    end

    assign last       = (cnt == CW'(1));
    assign res_next   = (op_q == OP_MULU) ? acc_n[NUMBITS-1:0] : sreg_n[NUMBITS-1:0];
    assign hi_nz_next = (op_q == OP_MULU) && (|acc_n[2*NUMBITS-1:NUMBITS]);

    // Load operands on start, then step once per cycle until the counter empties.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt  <= '0;
            op_q <= '0;
            sreg <= '0;
            acc  <= '0;
            mpl  <= '0;
        end else if (start) begin
            op_q <= op;
            sreg <= {{NUMBITS{1'b0}}, a};
            acc  <= '0;
            mpl  <= b;
            cnt  <= (op == OP_MULU) ? CW'(NUMBITS) : CW'(b[SHW-1:0]);
        end else if (cnt != '0) begin
            cnt  <= cnt - CW'(1);
            sreg <= sreg_n;
            acc  <= acc_n;
            mpl  <= mpl_n;
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU with valid/ready on both sides and registered result/flags.
// Handshake: an operation transfers on a rising edge with in_valid && in_ready;
// a result transfers on a rising edge with out_valid && out_ready, and result and
// flags hold steady while out_valid && !out_ready. One operation in flight.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int NUMBITS = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [NUMBITS-1:0] A,
    input  logic [NUMBITS-1:0] B,
    input  logic [3:0]         opcode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [NUMBITS-1:0] result,
    output logic               carryout,
    output logic               overflow,
    output logic               zero,
    output logic               err,
    output logic               busy
);

    localparam int SHW = $clog2(NUMBITS);

    state_t             state;
    logic               accept, go_iter, iter_start;
    logic               iter_last, iter_hi_nz;
    logic [NUMBITS-1:0] iter_res;
    logic [NUMBITS:0]   sum, diff;
    logic [NUMBITS-1:0] sc_res;
    logic               sc_carry, sc_ovf, sc_err;

    assign in_ready   = (state == IDLE) || (state == DONE && out_ready);
    assign accept     = in_valid && in_ready;
    // A shift by zero has nothing to iterate and completes like a single-cycle op.
    assign go_iter    = is_iterative(opcode) && ((opcode == OP_MULU) || (B[SHW-1:0] != '0));
    assign iter_start = accept && go_iter;

    assign sum  = {1'b0, A} + {1'b0, B};
    assign diff = {1'b0, A} - {1'b0, B};

    // Single-cycle result and flags, computed straight from the presented operands.
    always_comb begin
        sc_res   = '0;
        sc_carry = 1'b0;
        sc_ovf   = 1'b0;
        sc_err   = 1'b0;
        case (opcode)
            OP_ADDU: begin
                sc_res   = sum[NUMBITS-1:0];
                sc_carry = sum[NUMBITS];
            end
            OP_ADDS: begin
                sc_res = sum[NUMBITS-1:0];
                sc_ovf = (A[NUMBITS-1] == B[NUMBITS-1]) && (sum[NUMBITS-1] != A[NUMBITS-1]);
            end
            OP_SUBU: begin
                sc_res   = diff[NUMBITS-1:0];
                sc_carry = diff[NUMBITS];
            end
            OP_SUBS: begin
                sc_res = diff[NUMBITS-1:0];
                sc_ovf = (A[NUMBITS-1] != B[NUMBITS-1]) && (diff[NUMBITS-1] != A[NUMBITS-1]);
            end
            OP_AND:  sc_res = A & B;
            OP_OR:   sc_res = A | B;
            OP_XOR:  sc_res = A ^ B;
            OP_SRA1: sc_res = {A[NUMBITS-1], A[NUMBITS-1:1]};
            OP_SLL, OP_SRL, OP_SRA: sc_res = A;
            OP_MULU: sc_res = '0;
            default: begin
                sc_res = '1;
                sc_err = (opcode >= OP_ILLEGAL_MIN);
            end
        endcase
    end

    seq_alu_iter #(.NUMBITS(NUMBITS)) u_iter (
        .clk        (clk),
        .reset      (reset),
        .start      (iter_start),
        .op         (opcode),
        .a          (A),
        .b          (B),
        .last       (iter_last),
        .res_next   (iter_res),
        .hi_nz_next (iter_hi_nz)
    );

    // Control FSM with registered out_valid/busy and the result/flag registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            result    <= '0;
            carryout  <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (state == DONE && out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                    if (accept) begin
                        if (go_iter) begin
                            state     <= ITER;
                            busy      <= 1'b1;
                            out_valid <= 1'b0;
                        end else begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            result    <= sc_res;
                            carryout  <= sc_carry;
                            overflow  <= sc_ovf;
                            zero      <= (sc_res == '0);
                            err       <= sc_err;
                        end
                    end
                end
                ITER: begin
                    if (iter_last) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                        result    <= iter_res;
                        carryout  <= iter_hi_nz;
                        overflow  <= 1'b0;
                        zero      <= (iter_res == '0);
                        err       <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Directed and random checks of seq_alu against an arithmetic reference model.
module tb_seq_alu;

    localparam int N = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid, in_ready, out_valid, out_ready;
    logic [N-1:0] A, B, result;
    logic [3:0]   opcode;
    logic         carryout, overflow, zero, err, busy;

    int total = 0;
    int bad   = 0;
    logic [N-1:0] exp_q[$];

    // Clock and DUT
    always #5 clk = ~clk;

    seq_alu #(.NUMBITS(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .opcode    (opcode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carryout  (carryout),
        .overflow  (overflow),
        .zero      (zero),
        .err       (err),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference model: results from plain integer arithmetic.
    function automatic void ref_op(input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                                   output logic [N-1:0] r, output logic c, output logic o,
                                   output logic e, output int lat);
        int sa, sb, t, sh;
        logic signed [N-1:0] as;
        logic [2*N-1:0] p;
        sa = $signed(a);
        sb = $signed(b);
        as = a;
        sh = int'(b[3:0]);
        r = '0; c = 1'b0; o = 1'b0; e = 1'b0; lat = 1;
        case (op)
            4'd0: begin t = int'(a) + int'(b); r = t[N-1:0]; c = (t > 65535); end
            4'd1: begin t = sa + sb; r = t[N-1:0]; o = (t > 32767) || (t < -32768); end
            4'd2: begin r = a - b; c = (a < b); end
            4'd3: begin t = sa - sb; r = t[N-1:0]; o = (t > 32767) || (t < -32768); end
            4'd4: r = a & b;
            4'd5: r = a | b;
            4'd6: r = a ^ b;
            4'd7: r = as >>> 1;
            4'd8: begin r = a << sh; lat = 1 + sh; end
            4'd9: begin r = a >> sh; lat = 1 + sh; end
            4'd10: begin r = as >>> sh; lat = 1 + sh; end
            4'd11: begin
                p = {16'h0, a} * {16'h0, b};
                r = p[N-1:0];
                c = (p[2*N-1:N] != 0);
                lat = N + 1;
            end
            default: begin r = '1; e = 1'b1; end
        endcase
    endfunction

    // Driver: issue one op from IDLE, measure latency and busy cycles, check output.
    task automatic run_op(input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                          input string tag);
        logic [N-1:0] er;
        logic ec, eo, ee;
        int elat, lat, busy_cycles;
        ref_op(op, a, b, er, ec, eo, ee, elat);
        @(negedge clk);
        chk($sformatf("%s.in_ready", tag), in_ready, 1);
        in_valid = 1'b1; opcode = op; A = a; B = b; out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        A = N'($urandom); B = N'($urandom); opcode = 4'($urandom);
        lat = 1;
        busy_cycles = 0;
        @(negedge clk);
        while (!out_valid && lat < 64) begin
            if (busy && !in_ready) busy_cycles++;
            @(negedge clk);
            lat++;
        end
        chk($sformatf("%s.lat op=%0d", tag, op), lat, elat);
        chk($sformatf("%s.busy_cycles", tag), busy_cycles, elat - 1);
        chk($sformatf("%s.result op=%0d a=%h b=%h", tag, op, a, b), result, er);
        chk($sformatf("%s.carry", tag), carryout, ec);
        chk($sformatf("%s.ovf", tag), overflow, eo);
        chk($sformatf("%s.zero", tag), zero, (er == '0));
        chk($sformatf("%s.err", tag), err, ee);
    endtask

    initial begin
        logic [N-1:0] er, ra, rb;
        logic ec, eo, ee;
        logic [3:0] rop;
        int elat, seen;

        // Reset
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        A = '0; B = '0; opcode = '0;
        repeat (2) @(negedge clk);
        chk("rst.result", result, 0);
        chk("rst.out_valid", out_valid, 0);
        chk("rst.busy", busy, 0);
        chk("rst.flags", {carryout, overflow, zero, err}, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("rst.in_ready", in_ready, 1);

        // Directed
        run_op(4'd0,  16'hFFFF, 16'h0001, "addu_wrap");
        run_op(4'd1,  16'h7FFF, 16'h0001, "adds_ovf");
        run_op(4'd3,  16'h8000, 16'h0001, "subs_ovf");
        run_op(4'd2,  16'h0003, 16'h0005, "subu_borrow");
        run_op(4'd13, 16'h1234, 16'h5678, "illegal");
        run_op(4'd10, 16'h8000, 16'h0004, "sra4");
        run_op(4'd8,  16'h1234, 16'h0000, "sll0");
        run_op(4'd11, 16'h0100, 16'h0101, "mulu");
        run_op(4'd9,  16'hF0F0, 16'h000F, "srl15");
        run_op(4'd7,  16'h8001, 16'h0000, "sra1");
        run_op(4'd11, 16'hFFFF, 16'hFFFF, "mulu_max");

        // Random
        for (int i = 0; i < 50; i++)
            run_op(4'($urandom_range(0, 15)), N'($urandom), N'($urandom), "rand");

        // Back-to-back single-cycle ops with out_ready held high
        @(negedge clk);
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            if (i > 0) begin
                chk($sformatf("b2b.valid%0d", i), out_valid, 1);
                chk($sformatf("b2b.in_ready%0d", i), in_ready, 1);
                chk($sformatf("b2b.result%0d", i), result, exp_q.pop_front());
            end
            if (i < 6) begin
                rop = (i % 2 == 0) ? 4'd0 : 4'd6;
                ra = N'($urandom); rb = N'($urandom);
                ref_op(rop, ra, rb, er, ec, eo, ee, elat);
                exp_q.push_back(er);
                in_valid = 1'b1; opcode = rop; A = ra; B = rb;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end

        // Hold: result stays put while out_ready is low, new requests ignored
        in_valid = 1'b1; opcode = 4'd0; A = 16'h1111; B = 16'h2222; out_ready = 1'b0;
        @(posedge clk);
        #1;
        opcode = 4'd4; A = 16'hFFFF; B = 16'h0F0F;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("hold.valid%0d", i), out_valid, 1);
            chk($sformatf("hold.result%0d", i), result, 16'h3333);
            chk($sformatf("hold.in_ready%0d", i), in_ready, 0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("hold.drained", out_valid, 0);

        // Reset in the middle of a multiply
        in_valid = 1'b1; opcode = 4'd11; A = 16'h1234; B = 16'h5678;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (8) @(negedge clk);
        chk("rstmid.busy_before", busy, 1);
        reset = 1'b1;
        #1;
        chk("rstmid.out_valid", out_valid, 0);
        chk("rstmid.busy", busy, 0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("rstmid.in_ready", in_ready, 1);
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("rstmid.no_output", seen, 0);
        run_op(4'd5, 16'hA0A0, 16'h0505, "after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Multi-cycle successor to the single-cycle ALU, parametrised in NUMBITS.
- Adds a valid/ready handshake on both sides, registered result and flags, variable-amount iterative shifts, and an iterative unsigned multiply.
- Sits between operand fetch and writeback in the lab datapath.
- Only one operation is in flight at a time.

Parameters:
- NUMBITS, 16, operand/result width; legal range is NUMBITS >= 4.
- SHW, $clog2(NUMBITS), localparam; number of shift-amount bits taken from B.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous reset, active-high.
- in_valid  in  1  operands and opcode are valid.
- in_ready  out  1  block can accept an operation.
- A  in  NUMBITS  operand A.
- B  in  NUMBITS  operand B (shift amount = B[SHW-1:0]).
- opcode  in  4  operation select.
- out_valid  out  1  result and flags are valid.
- out_ready  in  1  consumer accepts the result.
- result  out  NUMBITS  registered result.
- carryout  out  1  unsigned carry/borrow, or multiply high-half-nonzero.
- overflow  out  1  signed overflow.
- zero  out  1  result == 0.
- err  out  1  illegal opcode.
- busy  out  1  iterative operation in progress.

Behaviour:
- Reset (async, active-high):
  - state=IDLE.
  - result, carryout, overflow, zero, err, out_valid, busy all 0.
  - in_ready=1 on the first clock after reset deasserts.
- Accept: an operation is accepted on a rising edge when in_valid && in_ready. A, B and opcode are captured into internal registers at that edge.
- in_ready = (state==IDLE) || (state==DONE && out_ready).
- States and transitions:
  - IDLE: on accept of a single-cycle op -> DONE. On accept of an iterative op -> ITER.
  - ITER: performs one step per cycle; goes to DONE when the step counter reaches 0.
  - DONE: out_valid=1. On out_ready, either go to IDLE, or re-accept if in_valid (next state chosen as from IDLE).
- Result hold: result and flags stay stable while out_valid && !out_ready.
- Opcodes and result rules:
  - 0 ADDU: result = A+B; carryout = bit NUMBITS of the sum.
  - 1 ADDS: two's-complement add; overflow = operands share a sign and result sign differs.
  - 2 SUBU: result = A-B; carryout = borrow (A<B unsigned).
  - 3 SUBS: overflow = operand signs differ and result sign differs from A.
  - 4 AND, 5 OR, 6 XOR: bitwise.
  - 7 SRA1: arithmetic shift right by 1.
  - 8 SLL, 9 SRL, 10 SRA: iterative shift by B[SHW-1:0], one bit per cycle.
  - 11 MULU: shift-add over exactly NUMBITS cycles. result = low NUMBITS bits of A*B; carryout = (high half != 0).
  - 12-15: illegal opcode; result all ones, err=1, completes in 1 cycle.
- Flag rules:
  - carryout and overflow are 0 for every opcode that does not define them.
  - zero = (final result == 0) for all opcodes, including illegal ones (so zero=0 there).
- Latency (from the accept edge to the out_valid rising edge):
  - Single-cycle ops: 1 cycle.
  - Shifts: 1 + shamt cycles; shamt=0 goes straight to DONE with latency 1.
  - MULU: NUMBITS + 1 cycles.
- busy=1 exactly while in ITER.
- in_ready=0 throughout ITER; in_valid is ignored there.
- Back-to-back: in DONE with out_ready && in_valid:
  - New op is single-cycle: out_valid stays 1 and the new result appears on the next edge.
  - New op is iterative: out_valid drops for the iteration cycles.
- Reset mid-ITER or mid-DONE: the operation is abandoned with no output.
- All arithmetic wraps modulo 2^NUMBITS.

Decomposition:
- Package seq_alu_pkg holds:
  - Opcode localparams (OP_ADDU .. OP_MULU, OP_ILLEGAL_MIN=12).
  - State encoding IDLE/ITER/DONE.
  - Function is_iterative(opcode).
- Sub-module seq_alu_iter holds the iterative shift/multiply datapath:
  - Step counter, shift register, accumulator.
  - start/done handshake with the top-level FSM.
- Single-cycle ops and the flags stay in the top level.

Test Plan (NUMBITS=16):
- ADDU A=0xFFFF B=0x0001 -> result 0x0000, carryout=1, zero=1, out_valid 1 cycle after accept.
- ADDS A=0x7FFF B=0x0001 -> 0x8000, overflow=1, carryout=0. SUBS A=0x8000 B=0x0001 -> 0x7FFF, overflow=1.
- SUBU A=0x0003 B=0x0005 -> 0xFFFE, carryout=1. Opcode 13 -> 0xFFFF, err=1, zero=0.
- SRA A=0x8000 B=0x0004 -> 0xF800, out_valid 5 cycles after accept, busy=1 and in_ready=0 for 4 cycles. SLL with B=0 -> A unchanged, latency 1.
- MULU A=0x0100 B=0x0101 -> result 0x0100, carryout=1, latency 17.
- Back-to-back ADDU/XOR with out_ready=1 -> out_valid continuously 1.
- Hold out_ready=0 for 3 cycles -> result stable, in_ready=0.
- Assert reset at MULU step 8 -> out_valid=0 and busy=0 immediately; in_ready=1 on the first clock after reset deasserts.
